// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//
// Parametrised UART transmitter. Serialises one word per frame as
//   start(0) | data LSB first | optional parity | 1 or 2 stop bits (1)
// Each bit is held for CLKS_PER_BIT cycles of i_clk_tx.
//
// A one-entry holding register sits behind a valid/ready handshake. It is
// emptied when its word moves into the shift register at the start of a frame.
// If a word is already waiting when a frame's final stop bit ends, the next
// start bit follows immediately, so an upstream source can stream words with
// no idle cycles between frames.
//
// Parameters
//   DATA_BITS    : data bits per frame, 5..9
//   CLKS_PER_BIT : clock cycles per bit, >= 2
//   PARITY_EN    : 1 inserts a parity bit after the data bits
//   PARITY_ODD   : 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)
//   STOP_BITS    : 1 or 2
//
// Ports
//   i_clk_tx : single clock, rising edge
//   i_reset  : synchronous active-high reset
//   i_data   : word to send, sampled only on an accepted handshake
//   i_valid  : upstream has a word
//   o_ready  : holding register empty (forced low during reset)
//   o_txd    : registered serial line, idles high
//   o_busy   : FSM not idle, or holding register full
//   o_done   : one-cycle pulse in the last cycle of the final stop bit
// -----------------------------------------------------------------------------
module uart_tx_frame #(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 i_clk_tx,
   input  logic                 i_reset,
   input  logic [DATA_BITS-1:0] i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic                 o_txd,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = $clog2(DATA_BITS);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic             PAR_EN    = (PARITY_EN != 0);
   localparam logic             PAR_ODD   = (PARITY_ODD != 0);

   // State
   logic [2:0]           state_q, state_d;
   logic [CNT_W-1:0]     baud_q, baud_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 parity_q, parity_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 hold_full_q, hold_full_d;
   logic                 txd_q, txd_d;
   logic                 done_q, done_d;

   logic accept;
   logic baud_end;
   logic load;

   assign o_ready  = ~hold_full_q & ~i_reset;
   assign accept   = i_valid & o_ready;
   assign baud_end = (baud_q == BAUD_LAST);

   // Next-state logic. The baud counter free-runs within a bit and is forced
   // back to zero on every bit boundary and every state entry.
   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q + CNT_W'(1);
      bit_d       = bit_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      load        = 1'b0;

      if (accept) begin
         hold_d      = i_data;
         hold_full_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (hold_full_q) begin
               load = 1'b1;
            end
         end

         S_START: begin
            if (baud_end) begin
               state_d = S_DATA;
               baud_d  = '0;
               bit_d   = '0;
            end
         end

         S_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = PAR_EN ? S_PARITY : S_STOP;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shift_d = shift_q >> 1;
               end
            end
         end

         S_PARITY: begin
            if (baud_end) begin
               state_d = S_STOP;
               baud_d  = '0;
               bit_d   = '0;
            end
         end

         S_STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == STOP_LAST) begin
                  bit_d = '0;
                  // A waiting word starts straight away: no idle gap.
                  if (hold_full_q) begin
                     load = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
            bit_d   = '0;
         end
      endcase

      // Moving the held word into the shift register frees the holding slot.
      // accept and load never coincide: accept needs the slot empty, load full.
      if (load) begin
         state_d     = S_START;
         baud_d      = '0;
         bit_d       = '0;
         shift_d     = hold_q;
         parity_d    = (^hold_q) ^ PAR_ODD;
         hold_full_d = 1'b0;
      end
   end

   // Line and done are registered from the next-state values, so o_txd changes
   // on the same edge the FSM changes state (start bit one cycle after accept).
   always_comb begin
      case (state_d)
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = shift_d[0];
         S_PARITY: txd_d = parity_d;
         default:  txd_d = 1'b1;
      endcase
      done_d = (state_d == S_STOP) && (bit_d == STOP_LAST) && (baud_d == BAUD_LAST);
   end

   always_ff @(posedge i_clk_tx) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         txd_q       <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         txd_q       <= txd_d;
         done_q      <= done_d;
      end
   end

   assign o_txd  = txd_q;
   assign o_done = done_q;
   assign o_busy = (state_q != S_IDLE) | hold_full_q;

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, successor to the fixed 8N1 `uart_tx`. It serialises one word per frame with the following compile-time options: data width, baud divisor, optional even/odd parity, and 1 or 2 stop bits. A one-entry holding register behind a valid/ready handshake lets an upstream FIFO or controller stream words with no idle gap between frames. `o_txd` feeds the pad or loops back into `uart_rx`.

## Interface
- `DATA_BITS`, default 8: data bits per frame. Legal range 5..9.
- `CLKS_PER_BIT`, default 16: `i_clk_tx` cycles per bit. Must be ≥ 2.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: 1 or 2.
- `i_clk_tx`, in, 1: the single clock. All logic is on the rising edge.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_data`, in, `DATA_BITS`: word to send. Sampled only on an accepted handshake.
- `i_valid`, in, 1: upstream has a word.
- `o_ready`, out, 1: holding register empty. Defined as `~hold_full & ~i_reset`.
- `o_txd`, out, 1: serial line, registered. Idles high.
- `o_busy`, out, 1: high when state ≠ IDLE or the holding register is full.
- `o_done`, out, 1: one-cycle pulse in the last cycle of the final stop bit.

## Operation
- **Handshake.** A word is accepted on any rising edge with `i_valid & o_ready`. `i_data` is copied into the holding register and `hold_full` is set. `i_data` at all other times is don't-care.
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `o_txd`=1. If `hold_full`, on the next edge:
  - go to START;
  - move the holding register into the shift register;
  - clear `hold_full`;
  - compute parity from the word.
- **START:** `o_txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:** bits are sent LSB first, each for `CLKS_PER_BIT` cycles. The bit counter runs 0..`DATA_BITS`-1. After the last bit, go to PARITY if `PARITY_EN`, else STOP.
- **PARITY:** bit = XOR of the data word, inverted when `PARITY_ODD`. Holds for `CLKS_PER_BIT` cycles, then go to STOP.
- **STOP:** `o_txd`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles. `o_done` is asserted in the last of these cycles. At the end of STOP:
  - if `hold_full`, go directly to START and load the next word (back-to-back);
  - otherwise go to IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1. It restarts on every bit boundary and on every state entry. It is sized `$clog2(CLKS_PER_BIT)`.
- **Buffering:** the holding register can be refilled at any time during a frame, as soon as it is emptied by a load. `o_ready` drops for exactly the cycles while `hold_full`=1.
- **Reset:** reset while `i_reset` is high, effective on the next edge. A reset mid-frame aborts the frame; no partial stop bit is driven.
  - state = IDLE; `hold_full`=0; counters = 0.
  - Outputs: `o_txd`=1, `o_done`=0, `o_busy`=0. `o_ready` is 0 while `i_reset`=1 and 1 on the first cycle after.

## Timing
- Frame length `F` = (1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles.
- Latency from an idle line:
  - handshake accepted at edge E0;
  - `o_txd` falls at E1, one cycle later;
  - `o_txd` is low for cycles E1..E1+`CLKS_PER_BIT`-1.
- `o_done` is high for the single cycle starting at edge E1+F-1.
- Back-to-back:
  - next word already held → the next start bit begins at E1+F;
  - zero idle cycles;
  - `o_done` pulses spaced exactly F cycles apart.
- `o_ready` low → `i_valid` is ignored and `i_data` may change freely.
- `o_busy` falls on the edge where the FSM enters IDLE with the holding register empty.

## Test plan
1. **8N1 single word.** `DATA_BITS`=8, `CLKS_PER_BIT`=4, send 8'h56.
   - `o_txd` at 4-cycle bit spacing: 0 | 0,1,1,0,1,0,1,0 | 1.
   - `o_done` in cycle 40 after the start bit begins; `o_busy` returns to 0 on the edge after.
2. **Parity.** Same word 8'h56, `PARITY_EN`=1.
   - Even: parity bit 0. Odd: parity bit 1.
   - F = 44 cycles.
3. **Back-to-back.** Present 8'h56, then 8'hA5 with `i_valid` held high.
   - Second start bit immediately follows the first stop bit.
   - 80 contiguous frame cycles; `o_done` pulses 40 cycles apart.
   - 8'hA5 bits on the line: 1,0,1,0,0,1,0,1.
4. **Format variant.** `DATA_BITS`=7, `STOP_BITS`=2, `CLKS_PER_BIT`=4, send 7'h41.
   - Frame 0 | 1,0,0,0,0,0,1 | 1,1, length 40.
   - `o_done` only in the last stop-bit cycle.
5. **Reset mid-frame.** Assert `i_reset` for 1 cycle during DATA bit 3 while the holding register is full.
   - Next edge: `o_txd`=1, `o_busy`=0, `o_done`=0.
   - Held word is discarded; `o_ready`=1 the cycle after reset.
   - No frame starts until a new handshake.
6. **Handshake integrity.** Keep `i_valid`=1 and change `i_data` every cycle while `o_ready`=0.
   - Only words present on edges with `o_ready`=1 are transmitted.
   - None are duplicated or dropped.
